// File: rtl/rgb_hsmooth.sv
// Horizontal 1-2-1 smoothing pre-filter for 24-bit RGB Avalon-ST video packets.
// Non-video packets, and packets started while mode is low, pass through unchanged.
`timescale 1ns/1ps
module rgb_hsmooth #(
  parameter int unsigned IMAGE_W = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  output logic        drop_pulse
);

  typedef enum logic [1:0] {StPass, StEmpty, StHold, StFlush} state_e;

  localparam logic [10:0] XLast = 11'(IMAGE_W - 1);

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d, xh_q, xh_d, x_inc;
  logic [23:0] l_q, l_d, h_q, h_d;
  logic [23:0] data_q, data_d;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, drop_q, drop_d;
  logic        free, accept, is_video_sop;
  logic [23:0] left_px, right_px, smooth_px;

  function automatic logic [23:0] smooth(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c);
    logic [23:0] res;
    logic [9:0]  sum;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = {2'b00, a[ch*8 +: 8]} + {1'b0, b[ch*8 +: 8], 1'b0} + {2'b00, c[ch*8 +: 8]};
      res[ch*8 +: 8] = sum[9:2];
    end
    return res;
  endfunction

  assign free         = ~valid_q | source_ready;
  assign sink_ready   = (state_q != StFlush) & free;
  assign accept       = sink_valid & sink_ready;
  assign is_video_sop = (sink_data[3:0] == 4'h0) & mode & ~sink_eop;
  assign x_inc        = (x_q == XLast) ? '0 : x_q + 11'd1;

  // Line ends replicate the held pixel instead of reaching into the neighbouring line.
  assign left_px   = (xh_q == '0) ? h_q : l_q;
  assign right_px  = ((state_q == StFlush) || (xh_q == XLast)) ? h_q : sink_data;
  assign smooth_px = smooth(left_px, h_q, right_px);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    xh_d    = xh_q;
    l_d     = l_q;
    h_d     = h_q;
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    drop_d  = 1'b0;
    if (free) valid_d = 1'b0;

    if (accept && sink_sop) begin
      valid_d = 1'b1;
      data_d  = sink_data;
      sop_d   = 1'b1;
      eop_d   = sink_eop;
      x_d     = '0;
      drop_d  = (state_q == StHold);
      state_d = is_video_sop ? StEmpty : StPass;
    end else begin
      unique case (state_q)
        StPass: begin
          if (accept) begin
            valid_d = 1'b1;
            data_d  = sink_data;
            sop_d   = 1'b0;
            eop_d   = sink_eop;
          end
        end
        StEmpty: begin
          if (accept) begin
            h_d     = sink_data;
            xh_d    = x_q;
            x_d     = x_inc;
            state_d = sink_eop ? StFlush : StHold;
          end
        end
        StHold: begin
          if (accept) begin
            valid_d = 1'b1;
            data_d  = smooth_px;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            l_d     = h_q;
            h_d     = sink_data;
            xh_d    = x_q;
            x_d     = x_inc;
            if (sink_eop) state_d = StFlush;
          end
        end
        StFlush: begin
          if (free) begin
            valid_d = 1'b1;
            data_d  = smooth_px;
            sop_d   = 1'b0;
            eop_d   = 1'b1;
            state_d = StPass;
          end
        end
        default: state_d = StPass;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StPass;
      x_q     <= '0;
      xh_q    <= '0;
      l_q     <= '0;
      h_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      xh_q    <= xh_d;
      l_q     <= l_d;
      h_q     <= h_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      drop_q  <= drop_d;
    end
  end

  assign source_valid = valid_q;
  assign source_data  = data_q;
  assign source_sop   = sop_q;
  assign source_eop   = eop_q;
  assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_rgb_hsmooth.sv
// Scoreboard bench for rgb_hsmooth: a packet-level reference model queues expected beats,
// and an independent monitor pops and compares them as the DUT emits output.
`timescale 1ns/1ps
module tb_rgb_hsmooth;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic [23:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;
  logic        drop_pulse;

  rgb_hsmooth #(.IMAGE_W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mode         (mode),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [25:0] exp_q[$];
  logic [23:0] pix[$];
  bit          vid_open = 1'b0;
  int          exp_drops = 0;
  int          drops_seen = 0;
  int          rdy_low = 0;
  bit          count_rdy = 1'b0;
  int          cyc = 0;
  int          bp_stop_cyc = 0;
  bit          rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endfunction

  // Smoothed value of packet pixel i; column is i mod W, line ends replicate the pixel itself.
  function automatic logic [23:0] ref_pixel(int i, bit last);
    logic [23:0] l, c, r, res;
    int col, s;
    col = i % W;
    c = pix[i];
    l = (col == 0) ? c : pix[i-1];
    r = (last || col == W - 1) ? c : pix[i+1];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'(l[ch*8 +: 8]) + 2 * int'(c[ch*8 +: 8]) + int'(r[ch*8 +: 8]);
      res[ch*8 +: 8] = 8'(s / 4);
    end
    return res;
  endfunction

  function automatic void model_accept(logic [23:0] d, bit s, bit e, bit m);
    int n;
    if (s) begin
      if (vid_open && pix.size() > 0) exp_drops++;
      pix.delete();
      vid_open = (d[3:0] == 4'h0) && m && !e;
      exp_q.push_back({d, 1'b1, e});
    end else if (vid_open) begin
      pix.push_back(d);
      n = pix.size();
      if (n >= 2) exp_q.push_back({ref_pixel(n - 2, 1'b0), 2'b00});
      if (e) begin
        exp_q.push_back({ref_pixel(n - 1, 1'b1), 2'b01});
        vid_open = 1'b0;
      end
    end else begin
      exp_q.push_back({d, 1'b0, e});
    end
  endfunction

  task automatic send_beat(input logic [23:0] d, input bit s, input bit e, input bit m);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      sink_valid = 1'b1;
      sink_data  = d;
      sink_sop   = s;
      sink_eop   = e;
      mode       = m;
      #4;
      if (sink_ready) begin
        model_accept(d, s, e, m);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL sink_timeout got ready=0 exp ready=1");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic drain(string name);
    int k;
    k = 0;
    idle();
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      #4;
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic send_line(input logic [23:0] desc, input logic [23:0] px[$], input bit eop_last);
    send_beat(desc, 1'b1, 1'b0, 1'b1);
    foreach (px[i]) send_beat(px[i], 1'b0, eop_last && (i == px.size() - 1), 1'b1);
  endtask

  task automatic rand_packet(input bit allow_bad);
    int kind, n;
    bit bad;
    logic [23:0] d;
    kind = $urandom_range(0, 9);
    n    = $urandom_range(1, 9);
    bad  = allow_bad && ($urandom_range(0, 5) == 0);
    d    = 24'($urandom);
    if (kind < 7) begin
      d[3:0] = 4'h0;
      send_beat(d, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        send_beat(24'($urandom), 1'b0, (i == n - 1) && !bad, 1'($urandom_range(0, 1)));
      end
    end else if (kind == 9) begin
      d[3:0] = 4'h0;
      send_beat(d, 1'b1, 1'b1, 1'b1);
    end else begin
      if (kind == 7) d[0] = 1'b1;
      else d[3:0] = 4'h0;
      send_beat(d, 1'b1, 1'b0, kind == 7);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        send_beat(24'($urandom), 1'b0, i == n - 1, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    source_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (cyc < bp_stop_cyc) source_ready = 1'b0;
      else if (rand_bp) source_ready = ($urandom_range(0, 3) != 0);
      else source_ready = 1'b1;
    end
  end

  // Monitor: pops on every output handshake and checks stalled beats stay put.
  logic [25:0] mon_got, mon_held, mon_exp;
  bit          mon_stalled = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset_n) begin
        mon_stalled = 1'b0;
        continue;
      end
      mon_got = {source_data, source_sop, source_eop};
      if (mon_stalled) begin
        checks++;
        if (!source_valid || mon_got !== mon_held) begin
          errors++;
          $display("FAIL stall_stable got v=%0b %h exp v=1 %h", source_valid, mon_got, mon_held);
        end
      end
      if (source_valid && source_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got %h exp none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL out_beat got %h exp %h", mon_got, mon_exp);
          end
        end
      end
      mon_stalled = source_valid && !source_ready;
      mon_held    = mon_got;
      if (drop_pulse) drops_seen++;
      if (count_rdy && !sink_ready) rdy_low++;
    end
  end

  initial begin
    logic [23:0] px[$];
    int base, dbase;
    reset_n    = 1'b0;
    mode       = 1'b0;
    sink_valid = 1'b0;
    sink_data  = '0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    #23;
    check("rst_valid", source_valid, 0);
    check("rst_data", source_data, 0);
    check("rst_sop", source_sop, 0);
    check("rst_eop", source_eop, 0);
    check("rst_drop", drop_pulse, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #4;
    check("rst_sink_ready", sink_ready, 1);

    // Non-video pass-through with one-cycle latency.
    dbase = drops_seen;
    send_beat(24'h00000F, 1'b1, 1'b0, 1'b1);
    send_beat(24'h123456, 1'b0, 1'b0, 1'b1);
    send_beat(24'hABCDEF, 1'b0, 1'b0, 1'b0);
    send_beat(24'h0F0F00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    sink_valid = 1'b0;
    #4;
    check("pass_latency", exp_q.size(), 0);
    drain("pass_drain");
    check("pass_no_drop", drops_seen - dbase, 0);

    // Flat frame of two rows, single FLUSH bubble, eop two cycles after acceptance.
    px.delete();
    for (int i = 0; i < 2 * W; i++) px.push_back(24'h808080);
    count_rdy = 1'b1;
    base = rdy_low;
    send_line(24'h000000, px, 1'b1);
    @(negedge clk);
    sink_valid = 1'b0;
    #4;
    check("eop_pending", exp_q.size(), 1);
    @(negedge clk);
    #4;
    check("eop_latency", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #4;
    count_rdy = 1'b0;
    check("flush_bubble", rdy_low - base, 1);
    drain("flat_drain");

    // Same frame with five cycles of downstream backpressure mid-packet.
    fork
      send_line(24'h000010, px, 1'b1);
      begin
        repeat (4) @(negedge clk);
        bp_stop_cyc = cyc + 5;
      end
    join
    drain("bp_drain");

    // Impulse in R on one line, then a two-line wrap pattern.
    px = '{24'h001010, 24'h641010, 24'h001010, 24'h001010};
    send_line(24'h000020, px, 1'b1);
    drain("impulse_drain");
    px = '{24'h280000, 24'h500000, 24'h780000, 24'hA00000,
           24'hC80000, 24'h000000, 24'h0A0000, 24'h140000};
    send_line(24'h000030, px, 1'b1);
    drain("wrap_drain");

    // Malformed: second sop arrives with a pixel still held.
    dbase = drops_seen;
    px = '{24'h112233, 24'h445566};
    send_line(24'h000040, px, 1'b0);
    px = '{24'h010203, 24'h040506, 24'h070809};
    send_line(24'h000050, px, 1'b1);
    drain("malformed_drain");
    check("malformed_drop", drops_seen - dbase, 1);

    // Randomised traffic with random backpressure.
    rand_bp = 1'b1;
    for (int p = 0; p < 60; p++) rand_packet(1'b1);
    rand_packet(1'b0);
    while (vid_open) rand_packet(1'b0);
    drain("random_drain");
    rand_bp = 1'b0;

    // Asynchronous reset in the middle of a video packet.
    send_beat(24'h000060, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_beat(24'($urandom), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    sink_valid = 1'b0;
    exp_q.delete();
    pix.delete();
    vid_open = 1'b0;
    #1;
    check("arst_valid", source_valid, 0);
    check("arst_data", source_data, 0);
    check("arst_drop", drop_pulse, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #4;
    check("arst_sink_ready", sink_ready, 1);
    px = '{24'h204060, 24'h6080A0, 24'h102030};
    send_line(24'h000070, px, 1'b1);
    drain("post_reset_drain");
    repeat (3) @(negedge clk);
    check("drop_total", drops_seen, exp_drops);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_hsmooth.md
# rgb_hsmooth

Avalon-ST video pre-filter placed directly upstream of the image-processing/colour-detection stage. It applies a horizontal 1-2-1 smoothing kernel to each RGB channel of video packets, which suppresses single-pixel noise before HSV thresholding. Non-video packets, and all packets while the filter is disabled, pass through unmodified. The block carries the same 24-bit sop/eop ready/valid stream on both sides.

## Interface
- IMAGE_W, 640: active line width in pixels; also the wrap point of the column counter.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  1  filter enable; sampled only on the sop beat.
- sink_data  in  24  {R,G,B} pixel or packet descriptor.
- sink_valid  in  1  input beat valid.
- sink_ready  out  1  input beat accepted when sink_valid & sink_ready.
- sink_sop  in  1  start of packet.
- sink_eop  in  1  end of packet.
- source_data  out  24  output beat data.
- source_valid  out  1  output beat valid (registered).
- source_ready  in  1  downstream ready.
- source_sop  out  1  start of packet.
- source_eop  out  1  end of packet.
- drop_pulse  out  1  one-cycle pulse when a held pixel is discarded because of a malformed packet.

## Operation
- The output register holds {source_data, source_sop, source_eop}. It is "free" when ~source_valid | source_ready.
- sink_ready = (state != FLUSH) & free.
- State machine:
  - PASS: idle or non-video. Every accepted beat is copied to the output register unchanged.
  - EMPTY: video, no pixel held.
  - HOLD: video, one pixel held.
  - FLUSH: video, held pixel is the eop pixel.
- Accepted sop beat, from PASS, EMPTY or HOLD:
  - The beat is forwarded unmodified and the column counter x is cleared to 0.
  - Next state is EMPTY if sink_data[3:0]==0, mode==1 and ~sink_eop; otherwise PASS.
  - If the sop beat arrives in HOLD, the held pixel is discarded and drop_pulse is asserted.
- Window registers: L (left neighbour), H (held pixel, with its column xH).
- EMPTY, non-eop pixel accepted: H <= pixel, xH <= x, x advances, go to HOLD. Nothing is output.
- HOLD, pixel N accepted:
  - Output f(L', H, R') with sop=0 and eop=0.
  - L' = H if xH==0, else L. R' = H if xH==IMAGE_W-1, else N.
  - Then L <= H, H <= N, xH <= x, x advances.
  - If N carries eop, go to FLUSH; otherwise stay in HOLD.
- EMPTY, eop pixel accepted: store it in H, go to FLUSH, no output.
- FLUSH, when the output register is free: output f(L', H, H) with eop=1 (L' as above), then go to PASS.
- Filter f, per channel: (a + 2b + c) >> 2, computed in a 10-bit sum and truncated with no rounding. A flat field is therefore unchanged.
- Column counter x (11 bits): increments per accepted video pixel and wraps from IMAGE_W-1 to 0. Line ends are handled by replication; there is no y counter.
- mode changes mid-packet have no effect.

## Timing
- Reset values:
  - source_valid=0, source_data=0, source_sop=0, source_eop=0, drop_pulse=0.
  - state=PASS, x=0, L=0, H=0.
  - sink_ready=1 after reset release.
- PASS latency: an accepted beat is visible on source the next cycle.
- Video latency: output pixel i is visible the cycle after pixel i+1 is accepted.
- The first pixel of a packet produces no output on acceptance.
- eop pixel, with source_ready held high: sink_ready is low for exactly 1 cycle (FLUSH), and the eop pixel is visible 2 cycles after its acceptance.
- Backpressure: with source_ready low, source_valid/data stay stable, sink_ready drops, and no state advances.
- Full throughput of 1 beat/cycle is sustained, except for the single FLUSH bubble per video packet.
- Asynchronous reset mid-packet aborts immediately. All state and outputs return to reset values, and the first accepted beat after release must be a sop.

## Test plan
- Non-video pass-through: sop beat with data 0x00000F, then 3 beats, mode=1. Output is identical to input, 1-cycle latency, drop_pulse never asserted.
- Flat frame: IMAGE_W=4, 2 rows of 0x808080, mode=1. Output is sop descriptor plus 8 pixels of 0x808080, eop only on the last, exactly one sink_ready-low cycle.
- Impulse on one line: IMAGE_W=4, R = 0,100,0,0. Output R = 25,50,25,0. The edge at x=0 uses replication, so (0+0+100)>>2 = 25.
- Line wrap: IMAGE_W=2, R = 40,80 | 200,0. Output R = 50,70,150,50, confirming no bleed across the line boundary.
- Backpressure: hold source_ready low for 5 cycles during the flat-frame test. Output data is unchanged and ordering is identical.
- Malformed packet: video sop, 2 pixels, new sop without eop. One drop_pulse, second pixel never output, new packet processed normally.
